// File: rtl/mux_serializer.sv
// ----------------------------------------------------------------------------
// mux_serializer
//
// Parallel-to-serial front end built around an N:1 bit multiplexer.
// The block accepts one N-bit word over a valid/ready handshake and stores it
// in a word register. It then steps the mux select through all N indices,
// advancing one index for each output beat that is accepted. When the last
// beat of a word is accepted in the same cycle that a new word is offered,
// the new word is loaded straight away, so back-to-back words leave no gap.
//
// Parameters
//   N          word width and mux input count (power of two, N >= 2)
//   K          select width, must equal log2(N)
//   MSB_FIRST  0: bit 0 goes out first, 1: bit N-1 goes out first
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   upstream word valid
//   in_ready   a word can be accepted this cycle (combinational on out_ready)
//   in_data    parallel word
//   out_valid  out_bit is valid
//   out_ready  downstream accepts out_bit
//   out_bit    currently selected bit, forced to 0 when out_valid is low
//   out_last   out_bit is the final bit of the current word
//   busy       a word is being serialized
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// mux
//
// N:1 bit multiplexer built as a balanced tree of 2:1 selects.
// Nodes are kept in a heap layout: node j has children 2j+1 (select bit 0)
// and 2j+2 (select bit 1), and the leaves N-1 .. 2N-2 hold a[0] .. a[N-1].
// The root level uses the select MSB, so the path from the root to leaf i
// spells out i in binary, MSB first.
//
// Ports
//   a  data inputs, one bit per index
//   s  select index
//   y  a[s]
// ----------------------------------------------------------------------------
module mux #(
   parameter int N = 8,
   parameter int K = 3
) (
   input  logic [N-1:0] a,
   input  logic [K-1:0] s,
   output logic         y
);

   logic [2*N-2:0] node;

   // Leaves.
   for (genvar i = 0; i < N; i++) begin : g_leaf
      assign node[N-1+i] = a[i];
   end

   // Internal levels: depth d holds 2**d nodes and is steered by s[K-1-d].
   for (genvar d = 0; d < K; d++) begin : g_level
      for (genvar p = 0; p < (1 << d); p++) begin : g_node
         localparam int J = (1 << d) - 1 + p;
         assign node[J] = s[K-1-d] ? node[2*J+2] : node[2*J+1];
      end
   end

   assign y = node[0];

endmodule

module mux_serializer #(
   parameter int N         = 8,
   parameter int K         = 3,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_bit,
   output logic         out_last,
   output logic         busy
);

   // Refuse to elaborate with a select that cannot address every input
   // exactly once.
   if (N < 2 || (1 << K) != N) begin : g_param_check
      $error("mux_serializer: N must be a power of two >= 2 and K == log2(N)");
   end

   // First and last select index of a word, fixed by the bit order.
   localparam logic [K-1:0] FIRST = MSB_FIRST ? K'(N-1) : K'(0);
   localparam logic [K-1:0] LAST  = MSB_FIRST ? K'(0)   : K'(N-1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   word_q,  word_d;
   logic [K-1:0]   sel_q,   sel_d;

   logic           mux_y;
   logic           beat;   // output beat accepted this cycle
   logic           load;   // input word accepted this cycle

   // -------------------------------------------------------------------------
   // Bit selection
   // -------------------------------------------------------------------------
   mux #(
      .N (N),
      .K (K)
   ) u_mux (
      .a (word_q),
      .s (sel_q),
      .y (mux_y)
   );

   // -------------------------------------------------------------------------
   // Outputs, all decoded from registered state except in_ready, which looks
   // at out_ready so a new word can slip in on the final beat.
   // -------------------------------------------------------------------------
   assign out_valid = (state_q == SHIFT);
   assign busy      = (state_q == SHIFT);
   assign out_last  = (state_q == SHIFT) && (sel_q == LAST);
   assign out_bit   = out_valid & mux_y;

   assign beat      = out_valid && out_ready;
   // Held low during reset so upstream never sees a handshake that the
   // register update below would throw away.
   assign in_ready  = rst_n && ((state_q == IDLE) || (beat && out_last));
   assign load      = in_valid && in_ready;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through
      // the branches below leaves one unassigned and no latch is inferred.
      state_d = state_q;
      word_d  = word_q;
      sel_d   = sel_q;

      unique case (state_q)
         IDLE: begin
            if (load) begin
               word_d  = in_data;
               sel_d   = FIRST;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (load) begin
               // Final beat accepted with a new word waiting: reload without
               // leaving SHIFT.
               word_d  = in_data;
               sel_d   = FIRST;
            end else if (beat) begin
               if (out_last) begin
                  state_d = IDLE;
               end else if (MSB_FIRST) begin
                  sel_d = sel_q - K'(1);
               end else begin
                  sel_d = sel_q + K'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         sel_q   <= sel_d;
      end
   end

endmodule
